// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array partial-sum drain path.
// Provides the drain FSM state type, the deskew latency and lane slicing.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } drain_state_t;

  // Cycles from start until the first fully aligned vector is present.
  function automatic int drain_latency(input int rows, input int cols);
    return rows + cols - 1;
  endfunction

  // Low bit of lane c in a packed COLS*w vector.
  function automatic int lane_lo(input int c, input int w);
    return c * w;
  endfunction

endpackage

// File: rtl/psum_fifo.sv
// Synchronous FIFO for aligned psum vectors; the head is held in storage registers.
// Ports: clk, rst, flush, push/din, pop/dout, full, empty.
module psum_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic             w_pop;
  logic             w_push;

  assign empty  = (r_cnt == '0);
  assign full   = (r_cnt == FULL_CNT);
  assign w_pop  = pop && !empty;
  // When full, a concurrent pop frees the slot being written.
  assign w_push = push && (!full || w_pop);
  assign dout   = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (w_pop && !w_push) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/systolic_psum_drain.sv
// Deskews bottom-row partial sums, counts a batch and buffers aligned vectors.
// Ports: clk, rst, transit, start, num_vecs, psum_in, m_* stream, busy, done, overflow.
module systolic_psum_drain
  import systolic_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int VEC_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   transit,
  input  logic                   start,
  input  logic [VEC_W-1:0]       num_vecs,
  input  logic [COLS*DATA_W-1:0] psum_in,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [COLS*DATA_W-1:0] m_data,
  output logic                   m_last,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  localparam int VW  = COLS * DATA_W;
  localparam int LAT = drain_latency(ROWS, COLS);
  localparam int CW  = $clog2(ROWS + COLS + 1);
  localparam logic [CW-1:0] FILL_END = CW'(LAT - 1);

  drain_state_t     r_state;
  drain_state_t     w_state_nxt;
  logic [CW-1:0]    r_cyc;
  logic [CW-1:0]    w_cyc_nxt;
  logic [CW-1:0]    w_cyc_inc;
  logic [VEC_W-1:0] r_num;
  logic [VEC_W-1:0] w_num_nxt;
  logic [VEC_W-1:0] r_vcnt;
  logic [VEC_W-1:0] w_vcnt_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_ovf;
  logic             w_capture;
  logic             w_last;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [VW-1:0]    w_aligned;
  logic [VW:0]      w_dout;

  // Lane c arrives c cycles after lane 0; delay it COLS-1-c cycles.
  for (genvar c = 0; c < COLS; c++) begin : g_lane
    localparam int D = COLS - 1 - c;
    logic [DATA_W-1:0] w_in;
    assign w_in = psum_in[lane_lo(c, DATA_W) +: DATA_W];
    if (D == 0) begin : g_pass
      assign w_aligned[lane_lo(c, DATA_W) +: DATA_W] = w_in;
    end else begin : g_dly
      logic [DATA_W-1:0] r_dl [D];
      always_ff @(posedge clk) begin
        if (rst || transit) begin
          for (int i = 0; i < D; i++) begin
            r_dl[i] <= '0;
          end
        end else begin
          r_dl[0] <= w_in;
          for (int i = 1; i < D; i++) begin
            r_dl[i] <= r_dl[i-1];
          end
        end
      end
      assign w_aligned[lane_lo(c, DATA_W) +: DATA_W] = r_dl[D-1];
    end
  end

  assign w_cyc_inc = r_cyc + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_cyc_nxt   = r_cyc;
    w_num_nxt   = r_num;
    w_vcnt_nxt  = r_vcnt;
    w_done_nxt  = 1'b0;
    w_capture   = 1'b0;
    w_last      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          if (num_vecs != '0) begin
            w_num_nxt   = num_vecs;
            w_cyc_nxt   = '0;
            w_vcnt_nxt  = '0;
            // A one-cycle latency leaves no room for FILL.
            w_state_nxt = (LAT == 1) ? DRAIN : FILL;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      FILL: begin
        // r_cyc counts cycles since start minus one.
        w_cyc_nxt = w_cyc_inc;
        if (w_cyc_inc >= FILL_END) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        w_capture  = 1'b1;
        w_last     = (r_vcnt == r_num - 1'b1);
        w_vcnt_nxt = r_vcnt + 1'b1;
        if (w_last) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || transit) begin
      r_state <= IDLE;
      r_cyc   <= '0;
      r_num   <= '0;
      r_vcnt  <= '0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cyc   <= w_cyc_nxt;
      r_num   <= w_num_nxt;
      r_vcnt  <= w_vcnt_nxt;
      r_done  <= w_done_nxt;
      if (w_capture && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign w_pop = m_valid && m_ready;

  psum_fifo #(
    .WIDTH(VW + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .flush(transit),
    .push (w_capture),
    .din  ({w_last, w_aligned}),
    .pop  (w_pop),
    .dout (w_dout),
    .full (w_full),
    .empty(w_empty)
  );

  assign m_valid  = !w_empty;
  assign m_data   = w_dout[VW-1:0];
  assign m_last   = !w_empty && w_dout[VW];
  assign busy     = (r_state != IDLE);
  assign done     = r_done;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_systolic_psum_drain.sv
// Scoreboard bench for systolic_psum_drain with skewed psum stimulus.
// Expected vectors are queued at launch; a negedge monitor pops and compares.
module tb_systolic_psum_drain;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int VW    = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 transit;
  logic                 start;
  logic [VW-1:0]        num_vecs;
  logic [COLS*DW-1:0]   psum_in = '0;
  logic                 m_valid;
  logic                 m_ready;
  logic [COLS*DW-1:0]   m_data;
  logic                 m_last;
  logic                 busy;
  logic                 done;
  logic                 overflow;

  typedef struct packed {
    logic [COLS*DW-1:0] data;
    logic               last;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   b_t = -1000;
  int   b_n = 0;
  int   b_base = 0;
  int   t0;
  int   t2;

  always #5 clk = ~clk;

  systolic_psum_drain #(
    .ROWS(ROWS),
    .COLS(COLS),
    .DATA_W(DW),
    .FIFO_DEPTH(DEPTH),
    .VEC_W(VW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .transit(transit),
    .start(start),
    .num_vecs(num_vecs),
    .psum_in(psum_in),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_last(m_last),
    .busy(busy),
    .done(done),
    .overflow(overflow)
  );

  // Array model: lane c of vector k appears at b_t+ROWS+c+k.
  always @(posedge clk) begin
    logic [COLS*DW-1:0] v;
    int k;
    cyc = cyc + 1;
    #1;
    for (int c = 0; c < COLS; c++) begin
      k = cyc - (b_t + ROWS + c);
      if (k >= 0 && k < b_n)
        v[c*DW +: DW] = DW'(b_base + 100 * k + c);
      else
        v[c*DW +: DW] = 32'hBAD0_0000 + DW'(c);
    end
    psum_in = v;
  end

  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got data %h last %b, required no output",
                 m_data, m_last);
      end else begin
        e_mon = sb.pop_front();
        if (m_data !== e_mon.data || m_last !== e_mon.last) begin
          n_err++;
          $display("FAIL sb_vector: got data %h last %b, required data %h last %b",
                   m_data, m_last, e_mon.data, e_mon.last);
        end
      end
    end
  end

  function automatic logic [COLS*DW-1:0] vec(input int base, input int k);
    logic [COLS*DW-1:0] v;
    for (int c = 0; c < COLS; c++) v[c*DW +: DW] = DW'(base + 100 * k + c);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upto(input int n);
    while (cyc < n) tick();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic expect_vecs(input int base, input int n, input int last_k);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.data = vec(base, k);
      e.last = (k == last_k);
      sb.push_back(e);
    end
  endtask

  task automatic launch(input int n, input int base, output int t);
    t = cyc;
    start = 1'b1;
    num_vecs = VW'(n);
    b_t = cyc;
    b_n = n;
    b_base = base;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    transit = 1'b0;
    start = 1'b0;
    num_vecs = '0;
    m_ready = 1'b1;
    repeat (3) tick();
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_last", 32'(m_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ovf", 32'(overflow), 0);
    rst = 1'b0;
    repeat (2) tick();

    // Basic batch of 3.
    expect_vecs(0, 3, 2);
    launch(3, 0, t0);
    upto(t0 + 7);
    chk("a_valid_early", 32'(m_valid), 0);
    upto(t0 + 8);
    chk("a_valid_first", 32'(m_valid), 1);
    upto(t0 + 9);
    chk("a_done_early", 32'(done), 0);
    chk("a_busy", 32'(busy), 1);
    upto(t0 + 10);
    chk("a_done", 32'(done), 1);
    chk("a_busy_end", 32'(busy), 0);
    upto(t0 + 11);
    chk("a_done_pulse", 32'(done), 0);
    chk("a_sb_empty", 32'(sb.size()), 0);
    repeat (3) tick();

    // Backpressure fills the FIFO exactly.
    m_ready = 1'b0;
    expect_vecs(1000, 8, 7);
    launch(8, 1000, t0);
    upto(t0 + 15);
    chk("b_done", 32'(done), 1);
    chk("b_ovf", 32'(overflow), 0);
    chk("b_valid_held", 32'(m_valid), 1);
    upto(t0 + 16);
    m_ready = 1'b1;
    upto(t0 + 23);
    chk("b_valid_b2b", 32'(m_valid), 1);
    upto(t0 + 24);
    chk("b_valid_empty", 32'(m_valid), 0);
    chk("b_sb_empty", 32'(sb.size()), 0);
    repeat (2) tick();

    // Overflow: vectors 8 and 9 dropped.
    m_ready = 1'b0;
    expect_vecs(2000, 8, -1);
    launch(10, 2000, t0);
    upto(t0 + 15);
    chk("c_ovf_before", 32'(overflow), 0);
    upto(t0 + 16);
    chk("c_ovf_set", 32'(overflow), 1);
    upto(t0 + 17);
    chk("c_done", 32'(done), 1);
    upto(t0 + 20);
    chk("c_ovf_sticky", 32'(overflow), 1);
    m_ready = 1'b1;
    upto(t0 + 28);
    chk("c_valid_empty", 32'(m_valid), 0);
    chk("c_ovf_after", 32'(overflow), 1);
    chk("c_sb_empty", 32'(sb.size()), 0);
    transit = 1'b1;
    tick();
    transit = 1'b0;
    chk("c_ovf_clear", 32'(overflow), 0);
    repeat (2) tick();

    // Push and pop together while full.
    m_ready = 1'b0;
    expect_vecs(3000, 12, 11);
    launch(12, 3000, t0);
    upto(t0 + 15);
    m_ready = 1'b1;
    upto(t0 + 16);
    chk("d_ovf_mid", 32'(overflow), 0);
    upto(t0 + 19);
    chk("d_done", 32'(done), 1);
    upto(t0 + 28);
    chk("d_ovf_end", 32'(overflow), 0);
    chk("d_valid_empty", 32'(m_valid), 0);
    chk("d_sb_empty", 32'(sb.size()), 0);
    repeat (2) tick();

    // Abort mid-batch, then restart.
    m_ready = 1'b0;
    launch(5, 4000, t0);
    upto(t0 + 8);
    chk("e_valid_pre", 32'(m_valid), 1);
    transit = 1'b1;
    tick();
    transit = 1'b0;
    chk("e_valid_flushed", 32'(m_valid), 0);
    chk("e_busy_flushed", 32'(busy), 0);
    m_ready = 1'b1;
    expect_vecs(5000, 1, 0);
    launch(1, 5000, t2);
    for (int i = 1; i < 8; i++) begin
      upto(t2 + i);
      chk("e_no_done", 32'(done), 0);
    end
    upto(t2 + 8);
    chk("e_done", 32'(done), 1);
    chk("e_valid", 32'(m_valid), 1);
    chk("e_last", 32'(m_last), 1);
    upto(t2 + 9);
    chk("e_sb_empty", 32'(sb.size()), 0);
    repeat (2) tick();

    // Empty batch.
    launch(0, 0, t0);
    chk("f_done", 32'(done), 1);
    chk("f_busy", 32'(busy), 0);
    chk("f_valid", 32'(m_valid), 0);
    tick();
    chk("f_done_pulse", 32'(done), 0);
    chk("f_valid_after", 32'(m_valid), 0);
    repeat (2) tick();

    // start during DRAIN must be ignored.
    expect_vecs(6000, 3, 2);
    launch(3, 6000, t0);
    upto(t0 + 8);
    start = 1'b1;
    num_vecs = VW'(5);
    tick();
    start = 1'b0;
    upto(t0 + 10);
    chk("g_done", 32'(done), 1);
    upto(t0 + 11);
    chk("g_busy", 32'(busy), 0);
    upto(t0 + 16);
    chk("g_valid_none", 32'(m_valid), 0);
    chk("g_done_none", 32'(done), 0);
    chk("g_sb_empty", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/systolic_psum_drain.md
Name: systolic_psum_drain

Overview:
- Collects partial sums leaving the bottom row of the weight-stationary PE array, one 32-bit lane per column.
- Column c results emerge c cycles later than column 0, so the block removes the column skew with per-column delay lines.
- It counts one batch of vectors and buffers the aligned result vectors in a FIFO.
- The FIFO streams to the downstream neuron/threshold stage over a valid/ready handshake. The array cannot stall, so the buffer absorbs backpressure.

Parameters:
- ROWS, 4, PE rows in the array; sets pipeline latency.
- COLS, 4, PE columns; number of output lanes.
- DATA_W, 32, partial-sum width per lane.
- FIFO_DEPTH, 8, aligned-vector buffer entries; power of two, ≥2.
- VEC_W, 16, width of the batch vector count.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- transit  in  1  synchronous abort/flush, same cycle the array clears.
- start  in  1  pulse; vector 0 enters row 0/col 0 of the array this cycle.
- num_vecs  in  VEC_W  vectors in the batch; sampled with start.
- psum_in  in  COLS*DATA_W  bottom-row out1 values; lane c = bits [c*DATA_W +: DATA_W].
- m_valid  out  1  output vector available.
- m_ready  in  1  consumer accepts when m_valid && m_ready.
- m_data  out  COLS*DATA_W  aligned result vector.
- m_last  out  1  marks the final vector of the batch.
- busy  out  1  high in FILL/DRAIN.
- done  out  1  one-cycle pulse after the last vector is captured.
- overflow  out  1  sticky; a capture was dropped because the FIFO was full.

Behaviour:
- Reset (rst) and transit: state IDLE, counters 0, delay lines 0, FIFO emptied.
  - Outputs: m_valid=0, m_last=0, busy=0, done=0, overflow=0.
  - Both take priority over every other input on the same edge.
- Timing contract: with start sampled high at cycle T, lane c of vector k is valid on psum_in at cycle T+ROWS+c+k.
- Deskew:
  - Lane c passes through COLS-1-c registers; lane COLS-1 has zero delay.
  - Aligned vector k is present at cycle T+ROWS+COLS-1+k.
- FSM:
  - IDLE: on start with num_vecs>0, latch num_vecs, clear the cycle counter, go to FILL. On start with num_vecs=0, pulse done next cycle and stay IDLE.
  - FILL: count cycles since T. When count reaches ROWS+COLS-2, go to DRAIN, so capture begins at the correct cycle.
  - DRAIN: capture one aligned vector per cycle and push it into the FIFO. The last bit is 1 for vector num_vecs-1. After num_vecs captures, pulse done on the next cycle and return to IDLE.
  - start while busy is ignored.
- FIFO:
  - Registered output, not fall-through; a pushed vector appears on m_data/m_valid one cycle after the capture edge.
  - m_data/m_last hold stable while m_valid && !m_ready.
  - Simultaneous push and pop is always legal, including when full; occupancy is unchanged.
  - Push when full without a pop drops the vector and sets overflow. The FSM still advances and done still pulses.
  - Pop when empty is ignored.
- Arithmetic: none; lanes pass through unmodified at DATA_W bits, with no wrap or saturation.
- Counters: the vector counter is VEC_W bits. The cycle counter is wide enough for ROWS+COLS.
- transit mid-batch: abort immediately. Partial vectors are discarded, no done pulse, and start is accepted from the next cycle.

Decomposition:
- Package systolic_pkg holds:
  - drain_state_t enum {IDLE, FILL, DRAIN};
  - localparam function drain_latency(ROWS,COLS)=ROWS+COLS-1;
  - lane slice helper macro/function.
- One sub-module: psum_fifo, a synchronous FIFO with registered output, carrying width COLS*DATA_W+1 (data plus last), flush input, full/empty flags.
- Deskew lines are inline generate loops.

Test Plan (ROWS=COLS=4, DATA_W=32, FIFO_DEPTH=8):
- Batch of 3, m_ready=1, start at T, lane c of vector k driven as 100*k+c at T+4+c+k:
  - captures at T+7..T+9;
  - m_valid at T+8..T+10 with m_data={0,1,2,3}, {100..103}, {200..203};
  - m_last only with vector 2; done at T+10.
- Backpressure: batch of 8 with m_ready=0 → FIFO full, overflow=0. Raising m_ready drains 8 vectors in order with back-to-back valid.
- Overflow: batch of 10 with m_ready=0 → vectors 8 and 9 dropped, overflow=1 sticky, done still pulses. Draining yields vectors 0..7 and m_last never asserts.
- Full-FIFO push/pop: FIFO at 8 entries with m_ready=1 during captures → no drop, overflow stays 0, order preserved.
- transit at T+8 of a 5-vector batch → m_valid=0 next cycle, no done. A new start at T+9 with num_vecs=1 yields one vector with m_last=1.
- Corner cases: start with num_vecs=0 → done pulse next cycle, no m_valid. start during DRAIN → ignored, capture count unchanged.
